// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Boot-time program loader. Parses a framed byte stream
//                (16-bit word count, little-endian payload words, 8-bit
//                checksum), writes each assembled word to instruction memory
//                and releases the core from reset once the frame checks out.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_reset,
  output logic        done,
  output logic        error
);

  localparam logic [2:0] S_LEN_LO = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_CSUM   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  localparam logic [31:0] c_max_words = 32'(MAX_WORDS);

  logic [2:0]  r_state;
  logic [2:0]  w_state_next;
  logic [7:0]  r_len_lo;
  logic [15:0] r_num_words;
  logic [1:0]  r_byte_idx;
  logic [15:0] r_word_idx;
  logic [7:0]  r_sum;
  logic [23:0] r_word;     // bytes 0..2 of the word being assembled, byte 0 lowest
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        w_hs;
  logic [15:0] w_len;
  logic        w_last_byte;
  logic        w_last_word;

  assign w_hs        = rx_valid & rx_ready;
  assign w_len       = {rx_data, r_len_lo};
  assign w_last_byte = (r_byte_idx == 2'd3);
  assign w_last_word = (r_word_idx == (r_num_words - 16'd1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_LEN_LO;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; every transition needs a handshake
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_LEN_LO: if (w_hs) w_state_next = S_LEN_HI;
      S_LEN_HI: begin
        if (w_hs) begin
          if ({16'd0, w_len} > c_max_words) begin
            w_state_next = S_ERR;
          end else if (w_len == 16'd0) begin
            w_state_next = S_CSUM;
          end else begin
            w_state_next = S_DATA;
          end
        end
      end
      S_DATA: if (w_hs && w_last_byte && w_last_word) w_state_next = S_CSUM;
      S_CSUM: begin
        if (w_hs) begin
          w_state_next = (rx_data == r_sum) ? S_DONE : S_ERR;
        end
      end
      S_DONE:  w_state_next = S_DONE;
      S_ERR:   w_state_next = S_ERR;
      default: w_state_next = S_ERR;
    endcase
  end

  // Status outputs are pure decodes of the current state
  always_comb begin
    rx_ready   = 1'b0;
    core_reset = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    case (r_state)
      S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM: rx_ready = 1'b1;
      S_DONE: begin
        core_reset = 1'b0;
        done       = 1'b1;
      end
      S_ERR:   error = 1'b1;
      default: error = 1'b1;
    endcase
  end

  // Datapath: length capture, word assembly, running sum and write port
  always_ff @(posedge clk) begin
    if (reset) begin
      r_len_lo    <= 8'd0;
      r_num_words <= 16'd0;
      r_byte_idx  <= 2'd0;
      r_word_idx  <= 16'd0;
      r_sum       <= 8'd0;
      r_word      <= 24'd0;
      r_we        <= 1'b0;
      r_addr      <= BASE_ADDR;
      r_wdata     <= 32'd0;
    end else begin
      r_we <= 1'b0;
      if (w_hs) begin
        case (r_state)
          S_LEN_LO: r_len_lo <= rx_data;
          S_LEN_HI: r_num_words <= w_len;
          S_DATA: begin
            r_sum      <= r_sum + rx_data;
            r_byte_idx <= r_byte_idx + 2'd1;
            r_word     <= {rx_data, r_word[23:8]};
            if (w_last_byte) begin
              // Address and data hold until the next write strobe
              r_we       <= 1'b1;
              r_addr     <= BASE_ADDR + {14'd0, r_word_idx, 2'b00};
              r_wdata    <= {rx_data, r_word};
              r_word_idx <= r_word_idx + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Randomised self-checking bench for imem_loader. The driver
//                builds frames, predicts the memory writes and final status
//                from the frame rules, and a negedge monitor pops predicted
//                writes whenever the DUT strobes imem_we.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  localparam logic [31:0] c_base = 32'h0000_0100;
  localparam int unsigned c_maxw = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_reset;
  logic        done;
  logic        error;

  imem_loader #(
    .BASE_ADDR(c_base),
    .MAX_WORDS(c_maxw)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .core_reset(core_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] exp_q[$];          // {addr, data} of every predicted write
  logic [63:0] mon_e;
  logic        prev_we = 1'b0;
  logic [7:0]  none_q[$];
  logic [7:0]  normal_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every write strobe must match the oldest predicted write
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {31'd0, imem_we}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_addr", imem_addr, mon_e[63:32]);
        chk("write_data", imem_wdata, mon_e[31:0]);
      end
      chk("we_single_cycle", {31'd0, prev_we}, 32'd0);
    end
    prev_we = imem_we;
  end

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    chk("writes_outstanding", exp_q.size(), 32'd0);
    chk("rst_rx_ready",   {31'd0, rx_ready},   32'd1);
    chk("rst_imem_we",    {31'd0, imem_we},    32'd0);
    chk("rst_imem_addr",  imem_addr,           c_base);
    chk("rst_imem_wdata", imem_wdata,          32'd0);
    chk("rst_core_reset", {31'd0, core_reset}, 32'd1);
    chk("rst_done",       {31'd0, done},       32'd0);
    chk("rst_error",      {31'd0, error},      32'd0);
    reset = 1'b0;
  endtask

  // One frame: n words, payload from fixed (or random), checksum xor'ed with
  // cxor (0 = good), random gaps in [glo,ghi], optional reset after rst_at
  // payload bytes (-1 = none; caller then resets).
  task automatic run_frame(input int unsigned n, input logic [7:0] fixed[$],
                           input logic [7:0] cxor, input int glo, input int ghi,
                           input int rst_at);
    logic [7:0]  pl[$];
    logic [7:0]  sum;
    logic [31:0] word;
    bit          ok;
    sum = 8'd0;
    ok  = (n <= c_maxw);
    if (ok) begin
      for (int i = 0; i < int'(4 * n); i++) begin
        pl.push_back((fixed.size() > 0) ? fixed[i] : 8'($urandom));
        sum = sum + pl[i];
      end
      for (int w = 0; w < int'(n); w++) begin
        word = {pl[4*w+3], pl[4*w+2], pl[4*w+1], pl[4*w]};
        if (rst_at < 0 || (4 * w + 3) < rst_at)
          exp_q.push_back({c_base + 32'(4 * w), word});
      end
    end
    idle($urandom_range(ghi, glo));
    send_byte(n[7:0]);
    idle($urandom_range(ghi, glo));
    send_byte(n[15:8]);
    if (!ok) begin
      chk("ovl_error",      {31'd0, error},      32'd1);
      chk("ovl_core_reset", {31'd0, core_reset}, 32'd1);
      chk("ovl_rx_ready",   {31'd0, rx_ready},   32'd0);
      send_byte(8'($urandom));
      send_byte(8'($urandom));
      chk("ovl_error_sticky", {31'd0, error}, 32'd1);
      chk("ovl_done",         {31'd0, done},  32'd0);
      return;
    end
    for (int i = 0; i < int'(4 * n); i++) begin
      if (rst_at >= 0 && i == rst_at) return;
      idle($urandom_range(ghi, glo));
      send_byte(pl[i]);
    end
    if (rst_at >= 0) return;
    idle($urandom_range(ghi, glo));
    send_byte(sum ^ cxor);
    // Status must be visible in the cycle right after the checksum edge
    chk("end_done",       {31'd0, done},       {31'd0, cxor == 8'd0});
    chk("end_error",      {31'd0, error},      {31'd0, cxor != 8'd0});
    chk("end_core_reset", {31'd0, core_reset}, {31'd0, cxor != 8'd0});
    chk("end_rx_ready",   {31'd0, rx_ready},   32'd0);
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    idle(2);
    chk("sticky_done",  {31'd0, done},  {31'd0, cxor == 8'd0});
    chk("sticky_error", {31'd0, error}, {31'd0, cxor != 8'd0});
    chk("frame_writes_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    int unsigned n;
    int          mode;
    normal_q = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
    @(negedge clk);
    do_reset();
    // Normal load
    run_frame(2, normal_q, 8'h00, 0, 0, -1);
    do_reset();
    // Zero-length frame
    run_frame(0, none_q, 8'h00, 0, 0, -1);
    do_reset();
    // Bad checksum (08 instead of 07)
    run_frame(2, normal_q, 8'h0F, 0, 0, -1);
    do_reset();
    // Over-limit length 257
    run_frame(257, none_q, 8'h00, 0, 0, -1);
    do_reset();
    // Largest accepted length
    run_frame(c_maxw, none_q, 8'h00, 0, 0, -1);
    do_reset();
    // Throttled input
    run_frame(2, normal_q, 8'h00, 3, 3, -1);
    do_reset();
    // Reset after 93 00 50, then a full replay
    run_frame(2, normal_q, 8'h00, 0, 0, 3);
    do_reset();
    run_frame(2, normal_q, 8'h00, 0, 0, -1);
    do_reset();
    // Random frames
    for (int f = 0; f < 30; f++) begin
      mode = $urandom_range(9, 0);
      if (mode == 0) begin
        run_frame($urandom_range(65535, c_maxw + 1), none_q, 8'h00, 0, 2, -1);
      end else if (mode <= 2) begin
        n = $urandom_range(5, 1);
        run_frame(n, none_q, 8'h00, 0, 2, $urandom_range(4 * n - 1, 0));
      end else begin
        run_frame($urandom_range(8, 0), none_q,
                  ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00,
                  0, 2, -1);
      end
      do_reset();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
